mips_mc_controller: RTL and testbench

Multicycle main-control sequencer for the MIPS core. It takes the opcode from the instruction register and steps the shared datapath through fetch, decode, execute, memory and writeback. The datapath has one ALU, one unified memory port and one register file. The controller issues every mux select and write enable, stalls on the memory ready handshake, and keeps a 16-bit retired-instruction counter. MIPS_TOP can route that counter to `test_value`.

---
 rtl/mips_mc_controller.sv | 198 +++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// mips_mc_controller
// Multicycle main-control sequencer for a MIPS core with one ALU, one unified
// memory port and one register file. Walks each instruction through fetch,
// decode, execute, memory and writeback. It drives every datapath mux select
// and write enable, and it counts retired instructions.
//
// Ports
//   CLK, RST          rising-edge clock; asynchronous active-low reset
//   Op[5:0]           opcode from the instruction register (Instr[31:26])
//   Zero              ALU zero flag (only consulted in BRANCH)
//   MemReady          unified memory completion (FETCH, MEMREAD, MEMWRITE)
//   PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0]   datapath controls
//   IllegalOp         one-cycle pulse in DECODE on an unsupported opcode
//   State[3:0]        current state code, exported for debug
//   InstrCount        retired-instruction counter, wraps silently
//
// Memory handshake: a memory access is requested for as long as the FSM sits
// in FETCH, MEMREAD or MEMWRITE. The request (address select, and MemWrite
// for a store) holds steady until a cycle with MemReady=1 completes it. The
// FSM then leaves the state on that same rising edge.
module mips_mc_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             IllegalOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;

  logic pc_write, branch, ir_write, mem_write, reg_write, illegal;
  logic retire;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_write  = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    IorD      = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        ir_write = MemReady;
        pc_write = MemReady;
        state_d  = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        state_d   = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      // Unused codes 12-15: all controls stay at their zero defaults and
      // the FSM goes back to FETCH.
      default: state_d = S_FETCH;
    endcase
  end

  // While RST is low the state is already FETCH. The enables are gated
  // directly by RST anyway, so that MemReady cannot raise IRWrite/PCEn
  // during reset, and so that an abort stops writes without waiting for
  // a clock edge.
  assign PCEn      = RST & (pc_write | (branch & Zero));
  assign IRWrite   = RST & ir_write;
  assign MemWrite  = RST & mem_write;
  assign RegWrite  = RST & reg_write;
  assign IllegalOp = RST & illegal;
  assign State     = state_q;

  // An instruction retires on the edge that returns from its final state to
  // FETCH. The illegal-opcode exit from DECODE is deliberately not counted.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        InstrCount <= '0;
    else if (retire) InstrCount <= InstrCount + 1'b1;
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed testbench for mips_mc_controller. Inputs change and outputs are
// sampled on the falling clock edge. The main DUT uses the default 16-bit
// counter. A second instance with a 4-bit counter shares the same inputs,
// so the wrap-around check stays short.
module tb_mips_mc_controller;

  logic       CLK;
  logic       RST;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;

  logic        PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic        ALUSrcA, IllegalOp;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic [3:0]  State;
  logic [15:0] InstrCount;

  logic        s_pcen, s_iord, s_memwrite, s_irwrite, s_regdst, s_memtoreg;
  logic        s_regwrite, s_alusrca, s_illegal;
  logic [1:0]  s_alusrcb, s_aluop, s_pcsrc;
  logic [3:0]  s_state;
  logic [3:0]  s_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = 16'd0;

  mips_mc_controller #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .IllegalOp(IllegalOp), .State(State), .InstrCount(InstrCount)
  );

  mips_mc_controller #(.CNT_W(4)) u_small (
    .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCEn(s_pcen), .IorD(s_iord), .MemWrite(s_memwrite), .IRWrite(s_irwrite),
    .RegDst(s_regdst), .MemtoReg(s_memtoreg), .RegWrite(s_regwrite),
    .ALUSrcA(s_alusrca), .ALUSrcB(s_alusrcb), .ALUOp(s_aluop), .PCSrc(s_pcsrc),
    .IllegalOp(s_illegal), .State(s_state), .InstrCount(s_count)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    MemReady = 1'b1;
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", State); end
    checks++; if (InstrCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", InstrCount); end
    checks++; if ({PCEn, IRWrite, MemWrite, RegWrite, IllegalOp} !== 5'b0) begin
      errors++; $display("FAIL reset_enables: got %b want 00000", {PCEn, IRWrite, MemWrite, RegWrite, IllegalOp});
    end
    checks++; if (ALUSrcB !== 2'b01) begin errors++; $display("FAIL reset_alusrcb: got %b want 01", ALUSrcB); end
    step();
    checks++; if (State !== 4'd0 || IRWrite !== 1'b0) begin
      errors++; $display("FAIL reset_hold: state %0d irwrite %b want 0 0", State, IRWrite);
    end
    RST = 1'b1;
    #1;
    checks++; if (IRWrite !== 1'b1 || PCEn !== 1'b1) begin
      errors++; $display("FAIL release_fetch: irwrite %b pcen %b want 1 1", IRWrite, PCEn);
    end
    exp_cnt = 16'd0;
  endtask

  task automatic test_fetch_stall();
    MemReady = 1'b0;
    Op = 6'b000010;
    #1;
    checks++; if (IRWrite !== 1'b0 || PCEn !== 1'b0) begin
      errors++; $display("FAIL fetch_stall_en: irwrite %b pcen %b want 0 0", IRWrite, PCEn);
    end
    step();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL fetch_stall_state: got %0d want 0", State); end
    MemReady = 1'b1;
    step(); step(); step();
    exp_cnt++;
    checks++; if (State !== 4'd0 || InstrCount !== exp_cnt) begin
      errors++; $display("FAIL fetch_stall_done: state %0d count %0d want 0 %0d", State, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    Op = 6'b100011;
    MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (State !== seq[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, State, seq[i]); end
      checks++; if (RegWrite !== (seq[i] == 4'd4) || MemtoReg !== (seq[i] == 4'd4)) begin
        errors++; $display("FAIL lw_wb[%0d]: regwrite %b memtoreg %b", i, RegWrite, MemtoReg);
      end
      if (seq[i] == 4'd1) begin
        checks++; if (ALUSrcB !== 2'b11) begin errors++; $display("FAIL decode_alusrcb: got %b want 11", ALUSrcB); end
      end
      if (seq[i] == 4'd3) begin
        checks++; if (IorD !== 1'b1) begin errors++; $display("FAIL lw_iord: got %b want 1", IorD); end
      end
      step();
    end
    exp_cnt++;
    checks++; if (State !== 4'd0 || InstrCount !== exp_cnt) begin
      errors++; $display("FAIL lw_done: state %0d count %0d want 0 %0d", State, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_sw_stall();
    int mw_cycles = 0;
    Op = 6'b101011;
    MemReady = 1'b1;
    step(); step();
    checks++; if (State !== 4'd2 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin
      errors++; $display("FAIL sw_memadr: state %0d srca %b srcb %b want 2 1 10", State, ALUSrcA, ALUSrcB);
    end
    step();
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReady = 1'b1;
      #1;
      if (MemWrite === 1'b1 && State === 4'd5) mw_cycles++;
      checks++; if (InstrCount !== exp_cnt) begin errors++; $display("FAIL sw_early_count[%0d]: got %0d want %0d", i, InstrCount, exp_cnt); end
      step();
    end
    exp_cnt++;
    checks++; if (mw_cycles != 4) begin errors++; $display("FAIL sw_memwrite_cycles: got %0d want 4", mw_cycles); end
    checks++; if (State !== 4'd0 || MemWrite !== 1'b0 || InstrCount !== exp_cnt) begin
      errors++; $display("FAIL sw_done: state %0d memwrite %b count %0d want 0 0 %0d", State, MemWrite, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_beq(input logic z);
    Op = 6'b000100;
    Zero = z;
    MemReady = 1'b1;
    step(); step();
    checks++; if (State !== 4'd8 || PCSrc !== 2'b01 || ALUOp !== 2'b01) begin
      errors++; $display("FAIL beq_state_z%0b: state %0d pcsrc %b aluop %b want 8 01 01", z, State, PCSrc, ALUOp);
    end
    checks++; if (PCEn !== z) begin errors++; $display("FAIL beq_pcen_z%0b: got %b want %b", z, PCEn, z); end
    step();
    exp_cnt++;
    checks++; if (State !== 4'd0 || InstrCount !== exp_cnt) begin
      errors++; $display("FAIL beq_done_z%0b: state %0d count %0d want 0 %0d", z, State, InstrCount, exp_cnt);
    end
    Zero = 1'b0;
  endtask

  task automatic test_rtype();
    Op = 6'b000000;
    step(); step();
    checks++; if (State !== 4'd6 || ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL rtype_exec: state %0d aluop %b srca %b regwrite %b", State, ALUOp, ALUSrcA, RegWrite);
    end
    step();
    checks++; if (State !== 4'd7 || RegDst !== 1'b1 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL rtype_wb: state %0d regdst %b regwrite %b want 7 1 1", State, RegDst, RegWrite);
    end
    step();
    exp_cnt++;
    checks++; if (State !== 4'd0 || InstrCount !== exp_cnt) begin
      errors++; $display("FAIL rtype_done: state %0d count %0d want 0 %0d", State, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_addi();
    Op = 6'b001000;
    step(); step();
    checks++; if (State !== 4'd9 || ALUSrcB !== 2'b10 || ALUSrcA !== 1'b1) begin
      errors++; $display("FAIL addi_exec: state %0d srcb %b srca %b want 9 10 1", State, ALUSrcB, ALUSrcA);
    end
    step();
    checks++; if (State !== 4'd10 || RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0) begin
      errors++; $display("FAIL addi_wb: state %0d regwrite %b regdst %b memtoreg %b", State, RegWrite, RegDst, MemtoReg);
    end
    step();
    exp_cnt++;
    checks++; if (State !== 4'd0 || InstrCount !== exp_cnt) begin
      errors++; $display("FAIL addi_done: state %0d count %0d want 0 %0d", State, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_jump();
    Op = 6'b000010;
    step(); step();
    checks++; if (State !== 4'd11 || PCSrc !== 2'b10 || PCEn !== 1'b1) begin
      errors++; $display("FAIL jump: state %0d pcsrc %b pcen %b want 11 10 1", State, PCSrc, PCEn);
    end
    step();
    exp_cnt++;
    checks++; if (State !== 4'd0 || InstrCount !== exp_cnt) begin
      errors++; $display("FAIL jump_done: state %0d count %0d want 0 %0d", State, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    Op = 6'b111111;
    checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL illegal_fetch: got %b want 0", IllegalOp); end
    step();
    checks++; if (State !== 4'd1 || IllegalOp !== 1'b1) begin
      errors++; $display("FAIL illegal_pulse: state %0d illegal %b want 1 1", State, IllegalOp);
    end
    step();
    checks++; if (State !== 4'd0 || IllegalOp !== 1'b0 || InstrCount !== exp_cnt) begin
      errors++; $display("FAIL illegal_after: state %0d illegal %b count %0d want 0 0 %0d", State, IllegalOp, InstrCount, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 16 - int'(exp_cnt[3:0]);
    Op = 6'b000010;
    MemReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      step(); step(); step();
      exp_cnt++;
      if (i == n - 2) begin
        checks++; if (s_count !== 4'd15) begin errors++; $display("FAIL wrap_max: got %0d want 15", s_count); end
      end
    end
    checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", s_count); end
    checks++; if (InstrCount !== exp_cnt) begin errors++; $display("FAIL wrap_wide: got %0d want %0d", InstrCount, exp_cnt); end
  endtask

  task automatic test_abort();
    Op = 6'b100011;
    MemReady = 1'b1;
    step(); step(); step(); step();
    checks++; if (State !== 4'd4 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL abort_pre: state %0d regwrite %b want 4 1", State, RegWrite);
    end
    #2 RST = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0 || State !== 4'd0 || InstrCount !== 16'd0) begin
      errors++; $display("FAIL abort_now: regwrite %b state %0d count %0d want 0 0 0", RegWrite, State, InstrCount);
    end
    exp_cnt = 16'd0;
    @(negedge CLK);
    RST = 1'b1;
    step();
    checks++; if (State !== 4'd1 || InstrCount !== 16'd0) begin
      errors++; $display("FAIL abort_restart: state %0d count %0d want 1 0", State, InstrCount);
    end
  endtask

  initial begin
    RST = 1'b0;
    Op = 6'd0;
    Zero = 1'b0;
    MemReady = 1'b0;
    test_reset();
    test_fetch_stall();
    test_lw();
    test_sw_stall();
    test_beq(1'b1);
    test_beq(1'b0);
    test_rtype();
    test_addi();
    test_jump();
    test_illegal();
    test_wrap();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
